digit_scan: RTL
===============

Name: digit_scan

Overview:
- Upstream stage of the digit lookup block in the VGA clock.
- Turns the raw pixel stream (display-enable, frame pulse) into per-digit block coordinates and the symbol code to draw.
- Drives that block's x_block, y_block and number inputs.
- Latches the six BCD time digits once per frame, so a displayed frame never mixes two times.

Parameters:
- BLOCK_PX, 4, screen pixels per font block, both axes; ≥1.
- FONT_W, 3, font width in blocks; each slot is FONT_W+1 blocks wide, the last block being the gap.
- FONT_H, 5, font height in blocks.
- NUM_SLOTS, 8, slots per line, fixed map H1 H0 : M1 M0 : S1 S0.
- X_ORIGIN, 8, first active pixel column of slot 0.
- Y_ORIGIN, 16, first active line of the digit row.

Ports:
- clk  in  1  pixel clock
- reset  in  1  asynchronous, active-low reset
- de  in  1  display enable, high during active pixels
- frame_start  in  1  one-cycle pulse once per frame, during vertical blanking
- digits  in  24  {H1,H0,M1,M0,S1,S0}, 4-bit BCD each, H1 in [23:20]
- x_block  out  6  block column within current slot, 0..FONT_W
- y_block  out  6  block row, 0..FONT_H-1
- number  out  4  symbol code: 0-9 digit, 10 colon, 11 blank
- in_area  out  1  high when x_block/y_block/number are valid for this pixel
- in_area_d  out  1  in_area delayed 1 cycle; aligns with the lookup block's registered outputs

Behaviour:
- Reset (reset=0, async) forces: x_block=0, y_block=0, number=11, in_area=0, in_area_d=0, all counters 0, frame_valid=0, latched digits = all 11.
- frame_valid is set by the first frame_start after reset. While frame_valid=0, in_area=0.
- All outputs are registered: 1 cycle after the pixel that produced them.
- Horizontal:
  - de rise (de=1, de_q=0) zeroes the pixel counter hx, sub_x, xb and slot.
  - hx increments on every de=1 cycle.
  - Once hx ≥ X_ORIGIN, sub_x counts 0..BLOCK_PX-1. On wrap, xb increments 0..FONT_W. On xb wrap, slot increments.
  - When slot reaches NUM_SLOTS, h_in goes low and the counters freeze until the next de rise.
  - de falling mid-slot simply abandons the line; there is no carry into the next line.
- Vertical:
  - frame_start zeroes vy, sub_y, yb and latches digits.
  - frame_start overrides a simultaneous de fall; it has no effect on horizontal state.
  - vy increments on each de fall.
  - While Y_ORIGIN ≤ vy < Y_ORIGIN+FONT_H*BLOCK_PX, v_in=1. sub_y counts lines 0..BLOCK_PX-1 and yb increments on its wrap.
- in_area = frame_valid & de & h_in & v_in & (hx ≥ X_ORIGIN).
- number:
  - Slots 2 and 5 give 10.
  - Other slots give their latched digit.
  - Any latched digit >9 gives 11.
  - When in_area=0, number=11 and x_block/y_block hold their last values.
- Changes to digits between frame_start pulses must not appear in the outputs.
- Counter widths: hx, vy 11 bits; sub_x, sub_y $clog2(BLOCK_PX+1); slot 4 bits.
- Overflow of hx/vy saturates, with no wrap into the display area.

Optional Feature:
- COLON_BLINK_EN defined: colon slots output 11 whenever latched S0[0]=1, so the colon blinks at 0.5 Hz.
- Not defined: colon slots always output 10.

Decomposition:
- Shared package digit_scan_pkg holds:
  - SYM_COLON=4'd10 and SYM_BLANK=4'd11;
  - the slot-map constant (slot index → digit field or colon);
  - the 6-bit block-coordinate width shared with the lookup block.
- One natural sub-module, block_axis_counter: sub-pixel counter plus block counter with a clear input and terminal count.
  - Instantiated once per axis.
  - Horizontal instance advances per pixel, vertical instance per line.

Test Plan (default parameters):
- Reset asserted mid-line with de=1 → number=11, in_area=0 immediately. After release, in_area stays 0 until the first frame_start.
- frame_start with digits=24'h123456, then line vy=16:
  - hx=8 → one cycle later x_block=0, number=1, in_area=1;
  - hx=12 → x_block=1;
  - hx=20 → x_block=3 (gap);
  - hx=24 → number=2;
  - hx=40 → number=10;
  - hx=136 → in_area=0.
- Vertical window: line 15 → in_area=0; lines 16-19 → y_block=0; line 20 → y_block=1; line 35 → y_block=4; line 36 → in_area=0.
- digits changed to 24'h235959 mid-frame → outputs keep 1,2,3,4,5,6 until the next frame_start, new values after it.
- digits H1=4'hC → slot 0 number=11. frame_start coincident with a de fall → vy=0.
- COLON_BLINK_EN with S0=5 → colon slots number=11; S0=4 → 10. in_area_d equals in_area delayed exactly 1 cycle throughout.

Source files
------------

// File: rtl/digit_scan_pkg.sv
// Shared types and constants for the VGA clock digit scanner and its lookup block.
// Slot map: H1 H0 : M1 M0 : S1 S0, with slot 0 leftmost.
package digit_scan_pkg;

  localparam logic [3:0] SYM_COLON = 4'd10;
  localparam logic [3:0] SYM_BLANK = 4'd11;
  localparam int         CRD_W     = 6;   // block-coordinate width shared with the lookup block
  localparam int         POS_W     = 11;  // pixel column / line counter width

  typedef enum logic [2:0] {
    F_S0, F_S1, F_M0, F_M1, F_H0, F_H1, F_COLON, F_NONE
  } slot_kind_e;

  function automatic slot_kind_e slot_kind(input logic [3:0] slot);
    slot_kind_e k;
    case (slot)
      4'd0:    k = F_H1;
      4'd1:    k = F_H0;
      4'd2:    k = F_COLON;
      4'd3:    k = F_M1;
      4'd4:    k = F_M0;
      4'd5:    k = F_COLON;
      4'd6:    k = F_S1;
      4'd7:    k = F_S0;
      default: k = F_NONE;
    endcase
    return k;
  endfunction

  function automatic logic [3:0] field_digit(input logic [23:0] d, input slot_kind_e k);
    logic [3:0] v;
    case (k)
      F_S0:    v = d[3:0];
      F_S1:    v = d[7:4];
      F_M0:    v = d[11:8];
      F_M1:    v = d[15:12];
      F_H0:    v = d[19:16];
      F_H1:    v = d[23:20];
      default: v = SYM_BLANK;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/digit_scan_block_axis_counter.sv
// Sub-pixel counter feeding a block counter; one instance per screen axis.
// blk is the effective value for this cycle (already zero when clr is high).
module block_axis_counter
  import digit_scan_pkg::*;
#(
  parameter int SUB_MAX  = 4,
  parameter int BLK_LAST = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             adv,
  output logic [CRD_W-1:0] blk,
  output logic             tc
);

  localparam int SUB_W = $clog2(SUB_MAX + 1);

  logic [SUB_W-1:0] sub_q;
  logic [SUB_W-1:0] sub;
  logic [CRD_W-1:0] blk_q;
  logic             sub_last;
  logic             blk_last;

  assign sub      = clr ? '0 : sub_q;
  assign blk      = clr ? '0 : blk_q;
  assign sub_last = (sub == SUB_W'(SUB_MAX - 1));
  assign blk_last = (blk == CRD_W'(BLK_LAST));
  assign tc       = adv & sub_last & blk_last;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sub_q <= '0;
      blk_q <= '0;
    end else if (adv) begin
      if (sub_last) begin
        sub_q <= '0;
        blk_q <= blk_last ? '0 : blk + 1'b1;
      end else begin
        sub_q <= sub + 1'b1;
        blk_q <= blk;
      end
    end else if (clr) begin
      sub_q <= '0;
      blk_q <= '0;
    end
  end

endmodule

// File: rtl/digit_scan.sv
// Turns the raw pixel stream into block coordinates and symbol codes for the digit lookup.
// Build option: define COLON_BLINK_EN to blank the colons whenever latched S0 is odd.
module digit_scan
  import digit_scan_pkg::*;
#(
  parameter int BLOCK_PX  = 4,
  parameter int FONT_W    = 3,
  parameter int FONT_H    = 5,
  parameter int NUM_SLOTS = 8,
  parameter int X_ORIGIN  = 8,
  parameter int Y_ORIGIN  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             de,
  input  logic             frame_start,
  input  logic [23:0]      digits,
  output logic [CRD_W-1:0] x_block,
  output logic [CRD_W-1:0] y_block,
  output logic [3:0]       number,
  output logic             in_area,
  output logic             in_area_d
);

  localparam int V_END = Y_ORIGIN + FONT_H * BLOCK_PX;

  logic             de_q;
  logic [POS_W-1:0] hx_q;
  logic [POS_W-1:0] vy_q;
  logic [3:0]       slot_q;
  logic             frame_valid;
  logic [23:0]      dig_q;

  logic             de_rise;
  logic             de_fall;
  logic [POS_W-1:0] hx_cur;
  logic [3:0]       slot_cur;
  logic             h_in;
  logic             h_past;
  logic             h_adv;
  logic             h_tc;
  logic             v_in;
  logic             v_adv;
  logic             v_tc_unused;
  logic             area;
  logic [CRD_W-1:0] h_blk;
  logic [CRD_W-1:0] v_blk;
  logic [3:0]       colon_sym;
  logic [3:0]       digit;
  logic [3:0]       sym;
  slot_kind_e       kind;

  // A de rise restarts the line, so this pixel sees zeroed horizontal state.
  assign de_rise  = de & ~de_q;
  assign de_fall  = ~de & de_q;
  assign hx_cur   = de_rise ? '0 : hx_q;
  assign slot_cur = de_rise ? '0 : slot_q;
  assign h_in     = (slot_cur < 4'(NUM_SLOTS));
  assign h_past   = (hx_cur >= POS_W'(X_ORIGIN));
  assign h_adv    = de & h_in & h_past;
  assign v_in     = (vy_q >= POS_W'(Y_ORIGIN)) && (vy_q < POS_W'(V_END));
  assign v_adv    = de_fall & v_in & ~frame_start;
  assign area     = frame_valid & de & h_in & v_in & h_past;

  block_axis_counter #(.SUB_MAX(BLOCK_PX), .BLK_LAST(FONT_W)) u_h_axis (
    .clk   (clk),
    .reset (reset),
    .clr   (de_rise),
    .adv   (h_adv),
    .blk   (h_blk),
    .tc    (h_tc)
  );

  block_axis_counter #(.SUB_MAX(BLOCK_PX), .BLK_LAST(FONT_H - 1)) u_v_axis (
    .clk   (clk),
    .reset (reset),
    .clr   (frame_start),
    .adv   (v_adv),
    .blk   (v_blk),
    .tc    (v_tc_unused)
  );

`ifdef COLON_BLINK_EN
  assign colon_sym = dig_q[0] ? SYM_BLANK : SYM_COLON;
`else
  assign colon_sym = SYM_COLON;
`endif

  always_comb begin
    kind  = slot_kind(slot_cur);
    digit = field_digit(dig_q, kind);
    sym   = SYM_BLANK;
    if (kind == F_COLON) sym = colon_sym;
    else if (digit <= 4'd9) sym = digit;
  end

  // Counters saturate so an overlong line or frame never wraps back into the digit row.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      de_q        <= 1'b0;
      hx_q        <= '0;
      vy_q        <= '0;
      slot_q      <= '0;
      frame_valid <= 1'b0;
      dig_q       <= {6{SYM_BLANK}};
    end else begin
      de_q <= de;
      if (de) begin
        hx_q   <= (hx_cur == {POS_W{1'b1}}) ? hx_cur : hx_cur + 1'b1;
        slot_q <= slot_cur + {3'b000, h_tc};
      end
      if (frame_start) begin
        vy_q        <= '0;
        dig_q       <= digits;
        frame_valid <= 1'b1;
      end else if (de_fall && vy_q != {POS_W{1'b1}}) begin
        vy_q <= vy_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x_block   <= '0;
      y_block   <= '0;
      number    <= SYM_BLANK;
      in_area   <= 1'b0;
      in_area_d <= 1'b0;
    end else begin
      in_area   <= area;
      in_area_d <= in_area;
      if (area) begin
        x_block <= h_blk;
        y_block <= v_blk;
        number  <= sym;
      end else begin
        number  <= SYM_BLANK;
      end
    end
  end

endmodule
